// File: rtl/fsm_persiana_pkg.sv
// Shared types and bit positions for the window-blind controller tile.
// State codes appear directly on uo_out[4:2].
package fsm_persiana_pkg;

  typedef enum logic [2:0] {
    ST_STOPPED = 3'd0,
    ST_OPEN    = 3'd1,
    ST_CLOSED  = 3'd2,
    ST_OPENING = 3'd3,
    ST_CLOSING = 3'd4,
    ST_FAULT   = 3'd5
  } state_e;

  localparam int UI_BTN_UP  = 0;
  localparam int UI_BTN_DN  = 1;
  localparam int UI_LIM_TOP = 2;
  localparam int UI_LIM_BOT = 3;
  localparam int UI_AUTO    = 4;
  localparam int UI_SUN     = 5;
  localparam int UI_WIND    = 6;
  localparam int UI_STOP    = 7;

  localparam int UO_MOT_UP  = 0;
  localparam int UO_MOT_DN  = 1;
  localparam int UO_ST_LO   = 2;
  localparam int UO_ST_HI   = 4;
  localparam int UO_FAULT   = 5;
  localparam int UO_BUSY    = 6;
  localparam int UO_ZERO    = 7;

endpackage

// File: rtl/persiana_timer.sv
// Travel watchdog counter: clear has priority over enable.
// expired flags the last permitted cycle of a motor run.
module persiana_timer #(
  parameter int TIMEOUT = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(TIMEOUT);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == W'(TIMEOUT - 1));

endmodule

// File: rtl/tt_um_fsm_yankel2025.sv
// Window-blind controller tile: command arbitration, Moore FSM
// and output decode; outputs depend on the state register only.
module tt_um_fsm_yankel2025
  import fsm_persiana_pkg::*;
#(
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  input  logic [7:0] uio_in,
  output logic [7:0] uo_out,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  state_e state_q;
  state_e state_d;

  logic btn_up, btn_dn, lim_top, lim_bot;
  logic auto_en, sun, wind, stop;
  logic cmd_up, cmd_dn;
  logic tmr_en, tmr_clr, tmr_exp;
  logic unused_ok;

  assign btn_up  = ui_in[UI_BTN_UP];
  assign btn_dn  = ui_in[UI_BTN_DN];
  assign lim_top = ui_in[UI_LIM_TOP];
  assign lim_bot = ui_in[UI_LIM_BOT];
  assign auto_en = ui_in[UI_AUTO];
  assign sun     = ui_in[UI_SUN];
  assign wind    = ui_in[UI_WIND];
  assign stop    = ui_in[UI_STOP];

  assign unused_ok = &{1'b0, ena, uio_in};

  // Buttons beat auto; wind beats everything; stop beats all but wind.
  always_comb begin
    cmd_up = 1'b0;
    cmd_dn = 1'b0;
    if (btn_up ^ btn_dn) begin
      cmd_up = btn_up;
      cmd_dn = btn_dn;
    end else if (!btn_up) begin
      cmd_up = auto_en & ~sun;
      cmd_dn = auto_en & sun;
    end
    if (wind) begin
      cmd_up = 1'b1;
      cmd_dn = 1'b0;
    end else if (stop) begin
      cmd_up = 1'b0;
      cmd_dn = 1'b0;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q != ST_FAULT && lim_top && lim_bot) begin
      state_d = ST_FAULT;
    end else begin
      case (state_q)
        ST_STOPPED: begin
          if (cmd_up && !lim_top)      state_d = ST_OPENING;
          else if (cmd_dn && !lim_bot) state_d = ST_CLOSING;
          else if (lim_top)            state_d = ST_OPEN;
          else if (lim_bot)            state_d = ST_CLOSED;
        end
        ST_OPEN: begin
          if (cmd_dn && !lim_bot) state_d = ST_CLOSING;
          else if (!lim_top)      state_d = ST_STOPPED;
        end
        ST_CLOSED: begin
          if (cmd_up && !lim_top) state_d = ST_OPENING;
          else if (!lim_bot)      state_d = ST_STOPPED;
        end
        ST_OPENING: begin
          if (lim_top)                         state_d = ST_OPEN;
          else if ((stop && !wind) || cmd_dn)  state_d = ST_STOPPED;
          else if (tmr_exp)                    state_d = ST_FAULT;
        end
        ST_CLOSING: begin
          if (lim_bot)                       state_d = ST_CLOSED;
          else if (wind || stop || cmd_up)   state_d = ST_STOPPED;
          else if (tmr_exp)                  state_d = ST_FAULT;
        end
        ST_FAULT: state_d = ST_FAULT;
        default:  state_d = ST_FAULT;
      endcase
    end
  end

  // Count only while a run continues; any entry or exit clears.
  always_comb begin
    tmr_en  = (state_q == ST_OPENING && state_d == ST_OPENING) ||
              (state_q == ST_CLOSING && state_d == ST_CLOSING);
    tmr_clr = ~tmr_en;
  end

  persiana_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clr    (tmr_clr),
    .en     (tmr_en),
    .expired(tmr_exp)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_STOPPED;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    uo_out                    = '0;
    uo_out[UO_MOT_UP]         = (state_q == ST_OPENING);
    uo_out[UO_MOT_DN]         = (state_q == ST_CLOSING);
    uo_out[UO_ST_HI:UO_ST_LO] = state_q;
    uo_out[UO_FAULT]          = (state_q == ST_FAULT);
    uo_out[UO_BUSY]           = uo_out[UO_MOT_UP] | uo_out[UO_MOT_DN];
    uo_out[UO_ZERO]           = 1'b0;
  end

  assign uio_out = '0;
  assign uio_oe  = '0;

endmodule

// File: tb/tb_tt_um_fsm_yankel2025.sv
// Scoreboard bench for the window-blind controller tile.
// Expected uo_out bytes are queued at drive time, popped after each edge.
module tb_tt_um_fsm_yankel2025;

  logic       clk;
  logic       rst;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uio_in;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int tests_run;
  int tests_failed;
  logic [7:0] exp_q[$];

  tt_um_fsm_yankel2025 #(
    .TIMEOUT(16)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .ena    (ena),
    .ui_in  (ui_in),
    .uio_in (uio_in),
    .uo_out (uo_out),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    ui_in = 8'h00;
    rst   = 1'b1;
    #2;
    rst   = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    logic [7:0] e;
    rst    = 1'b1;
    ui_in  = 8'h00;
    #2;
    tests_run++;
    if (uo_out !== 8'h00 || uio_out !== 8'h00 || uio_oe !== 8'h00) begin
      tests_failed++;
      $display("FAIL reset_async uo=%h uio_out=%h uio_oe=%h want 00",
               uo_out, uio_out, uio_oe);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(8'h00);
      ui_in = 8'h00;
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      tests_run++;
      if (uo_out !== e) begin
        tests_failed++;
        $display("FAIL reset_hold[%0d] got %h want %h", i, uo_out, e);
      end
    end
  endtask

  task automatic test_manual_open_auto_close();
    logic [7:0] ui [5] = '{8'h01, 8'h05, 8'h34, 8'h30, 8'h38};
    logic [7:0] ex [5] = '{8'h4D, 8'h04, 8'h52, 8'h52, 8'h08};
    logic [7:0] e;
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(ex[i]);
      ui_in = ui[i];
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      tests_run++;
      if (uo_out !== e) begin
        tests_failed++;
        $display("FAIL open_close[%0d] ui=%h got %h want %h",
                 i, ui[i], uo_out, e);
      end
    end
  endtask

  task automatic test_wind();
    logic [7:0] ui [5] = '{8'h02, 8'h42, 8'h42, 8'h40, 8'hC0};
    logic [7:0] ex [5] = '{8'h52, 8'h00, 8'h4D, 8'h4D, 8'h4D};
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(ex[i]);
      ui_in = ui[i];
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      tests_run++;
      if (uo_out !== e) begin
        tests_failed++;
        $display("FAIL wind[%0d] ui=%h got %h want %h", i, ui[i], uo_out, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ui [8] = '{8'h01, 8'h02, 8'h02, 8'h01, 8'h01,
                           8'h81, 8'h10, 8'h30};
    logic [7:0] ex [8] = '{8'h4D, 8'h00, 8'h52, 8'h00, 8'h4D,
                           8'h00, 8'h4D, 8'h00};
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back(ex[i]);
      ui_in = ui[i];
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      tests_run++;
      if (uo_out !== e) begin
        tests_failed++;
        $display("FAIL b2b[%0d] ui=%h got %h want %h", i, ui[i], uo_out, e);
      end
    end
  endtask

  task automatic test_mid_reset();
    logic [7:0] e;
    do_reset();
    exp_q.push_back(8'h4D);
    ui_in = 8'h01;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    tests_run++;
    if (uo_out !== e) begin
      tests_failed++;
      $display("FAIL mid_reset_run got %h want %h", uo_out, e);
    end
    rst = 1'b1;
    #1;
    tests_run++;
    if (uo_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL mid_reset_async got %h want 00", uo_out);
    end
    #1;
    rst = 1'b0;
    exp_q.push_back(8'h00);
    ui_in = 8'h00;
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    tests_run++;
    if (uo_out !== e) begin
      tests_failed++;
      $display("FAIL mid_reset_after got %h want %h", uo_out, e);
    end
  endtask

  task automatic test_watchdog();
    logic [7:0] junk [5] = '{8'h00, 8'h0C, 8'h02, 8'hFF, 8'h01};
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < 22; i++) begin
      if (i < 16)      exp_q.push_back(8'h4D);
      else             exp_q.push_back(8'h34);
      ui_in = (i < 17) ? 8'h01 : junk[i-17];
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      tests_run++;
      if (uo_out !== e) begin
        tests_failed++;
        $display("FAIL watchdog[%0d] ui=%h got %h want %h",
                 i, ui_in, uo_out, e);
      end
    end
    do_reset();
    tests_run++;
    if (uo_out !== 8'h00) begin
      tests_failed++;
      $display("FAIL fault_clear got %h want 00", uo_out);
    end
  endtask

  task automatic test_limits_buttons();
    logic [7:0] ui [4] = '{8'h03, 8'h03, 8'h0C, 8'h00};
    logic [7:0] ex [4] = '{8'h00, 8'h00, 8'h34, 8'h34};
    logic [7:0] e;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(ex[i]);
      ui_in = ui[i];
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      tests_run++;
      if (uo_out !== e) begin
        tests_failed++;
        $display("FAIL limits[%0d] ui=%h got %h want %h", i, ui[i], uo_out, e);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    ena          = 1'b1;
    uio_in       = 8'h00;
    ui_in        = 8'h00;
    rst          = 1'b1;
    test_reset();
    test_manual_open_auto_close();
    test_wind();
    test_back_to_back();
    test_mid_reset();
    test_watchdog();
    test_limits_buttons();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
